// File: rtl/psum_accumulator.sv
// psum_accumulator: multi-row partial-sum accumulator for a matrix engine.
// Each accepted beat carries LANES signed partial products for one of DEPTH
// accumulator rows. A first beat overwrites the row, later beats add to it with
// saturation, and a last beat pushes the finished row (plus a sticky
// saturation flag) into a 2-entry in-order output FIFO.
//
// Ports:
//   clk, rst              - clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready     - input beat handshake (in_ready = FIFO has room)
//   in_data               - LANES x ACC_W signed lanes, lane 0 in the LSBs
//   in_row                - target accumulator row
//   in_first / in_last    - first K-pass (overwrite) / final K-pass (emit row)
//   out_valid/out_ready   - output row handshake (FIFO head)
//   out_data, out_sat     - completed row and its saturation flag
//   err                   - one-cycle pulse on a first/active or non-first/idle hit
//   busy                  - any row mid-accumulation or FIFO non-empty

// One lane column: holds this lane's accumulator for every row and produces the
// saturated next value for the addressed row.
module psum_lane #(
    parameter int ACC_W = 24,
    parameter int DEPTH = 4,
    parameter int RW    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [RW-1:0]    row,
    input  logic             use_acc,
    input  logic [ACC_W-1:0] din,
    output logic [ACC_W-1:0] sum,
    output logic             clamp
);
    logic [ACC_W-1:0] acc [DEPTH];
    logic [ACC_W-1:0] base;
    logic [ACC_W:0]   full;

    always_comb begin
        // A first beat, or a beat to an idle row, adds to zero, so it can never clamp.
        base  = use_acc ? acc[row] : '0;
        full  = {base[ACC_W-1], base} + {din[ACC_W-1], din};
        // Overflow shows up as the two top bits of the widened sum disagreeing.
        clamp = full[ACC_W] ^ full[ACC_W-1];
        if (clamp)
            sum = full[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        else
            sum = full[ACC_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) acc[i] <= '0;
        end else if (we) begin
            acc[row] <= sum;
        end
    end
endmodule

module psum_accumulator #(
    parameter int LANES = 16,
    parameter int ACC_W = 24,
    parameter int DEPTH = 4,
    localparam int RW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int DW   = LANES * ACC_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic [RW-1:0] in_row,
    input  logic          in_first,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_sat,
    output logic          err,
    output logic          busy
);
    typedef struct packed {
        logic [DW-1:0] data;
        logic          sat;
    } row_t;

    logic [LANES-1:0][ACC_W-1:0] lane_in, lane_sum;
    logic [LANES-1:0]            lane_clamp;
    logic [DEPTH-1:0]            active, sat;
    row_t                        fifo [2];
    logic                        rd_ptr, wr_ptr;
    logic [1:0]                  cnt;
    logic                        accept, push, pop, use_acc, row_sat;

    assign lane_in   = in_data;
    assign in_ready  = !rst && (cnt < 2'd2);
    assign accept    = in_valid && in_ready;
    // Only a non-first beat to a row already in progress builds on stored state.
    assign use_acc   = !in_first && active[in_row];
    assign row_sat   = (use_acc && sat[in_row]) || (|lane_clamp);
    assign push      = accept && in_last;
    assign pop       = out_valid && out_ready;
    assign out_valid = (cnt != 2'd0);
    assign out_data  = fifo[rd_ptr].data;
    assign out_sat   = fifo[rd_ptr].sat;
    assign busy      = (|active) || (cnt != 2'd0);

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        psum_lane #(.ACC_W(ACC_W), .DEPTH(DEPTH), .RW(RW)) u_lane (
            .clk     (clk),
            .rst     (rst),
            .we      (accept),
            .row     (in_row),
            .use_acc (use_acc),
            .din     (lane_in[g]),
            .sum     (lane_sum[g]),
            .clamp   (lane_clamp[g])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active <= '0;
            sat    <= '0;
            err    <= 1'b0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            cnt    <= 2'd0;
            for (int i = 0; i < 2; i++) fifo[i] <= '0;
        end else begin
            // Protocol error: first beat to an active row, or non-first to an idle row.
            err <= accept && (in_first == active[in_row]);
            if (accept) begin
                active[in_row] <= !in_last;
                sat[in_row]    <= row_sat;
            end
            if (push) begin
                fifo[wr_ptr].data <= lane_sum;
                fifo[wr_ptr].sat  <= row_sat;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end
endmodule
